// File: rtl/cam_pkg.sv
// Shared types and defaults for the camera capture controller.
package cam_pkg;

    localparam int unsigned H_BYTES_DEF = 320;
    localparam int unsigned V_LINES_DEF = 120;
    localparam int unsigned ADDR_W      = 15;
    localparam int unsigned PIX_W       = 12;
    localparam int unsigned BYTE_CNT_W  = 9;
    localparam int unsigned LINE_CNT_W  = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT_VS,
        ST_CAPTURE,
        ST_DONE
    } cam_state_e;

    function automatic logic [BYTE_CNT_W-1:0] byte_inc(input logic [BYTE_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [LINE_CNT_W-1:0] line_inc(input logic [LINE_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Two-flop synchronizer for one camera pin, with single-cycle rise/fall pulses
// derived from the synchronized level.
module cam_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = async_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/cam_capture_ctrl.sv
// Frame capture sequencer for a parallel camera bus.
// Define CAP_FRAME_CHECK_EN to build the sticky frame-geometry error flag.
module cam_capture_ctrl
    import cam_pkg::*;
#(
    parameter int unsigned H_BYTES = H_BYTES_DEF,
    parameter int unsigned V_LINES = V_LINES_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  CAM_PCLK,
    input  logic                  CAM_HREF,
    input  logic                  CAM_VSYNC,
    input  logic                  start,
    input  logic                  mode_cont,
    input  logic                  abort,
    output logic                  cap_en,
    output logic                  addr_clr,
    output logic                  busy,
    output logic                  frame_done,
    output logic [LINE_CNT_W-1:0] line_cnt,
    output logic                  err
);

    localparam logic [LINE_CNT_W-1:0] V_LINES_C = LINE_CNT_W'(V_LINES);

    logic pclk_rise, href_s, href_fall, vs_rise, vs_fall;
    logic [3:0] sync_unused;

    cam_sync_edge u_pclk_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .async_i(CAM_PCLK),
        .sync_o (sync_unused[0]),
        .rise_o (pclk_rise),
        .fall_o (sync_unused[1])
    );

    cam_sync_edge u_href_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .async_i(CAM_HREF),
        .sync_o (href_s),
        .rise_o (sync_unused[2]),
        .fall_o (href_fall)
    );

    cam_sync_edge u_vsync_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .async_i(CAM_VSYNC),
        .sync_o (sync_unused[3]),
        .rise_o (vs_rise),
        .fall_o (vs_fall)
    );

    cam_state_e              state_q, state_d;
    logic                    mode_q, mode_d;
    logic                    addr_clr_q, addr_clr_d;
    logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [LINE_CNT_W-1:0]   line_cnt_q, line_cnt_d;
    logic                    start_ok;

    // abort outranks start, so a simultaneous request never leaves IDLE
    assign start_ok = start && !abort && (state_q == ST_IDLE);

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        addr_clr_d = 1'b0;
        byte_cnt_d = byte_cnt_q;
        line_cnt_d = line_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_ARM;
                    mode_d  = mode_cont;
                end
            end
            ST_ARM: begin
                if (vs_rise) state_d = ST_WAIT_VS;
            end
            ST_WAIT_VS: begin
                if (vs_fall) begin
                    state_d    = ST_CAPTURE;
                    addr_clr_d = 1'b1;
                    byte_cnt_d = '0;
                    line_cnt_d = '0;
                end
            end
            ST_CAPTURE: begin
                if (pclk_rise && href_s) byte_cnt_d = byte_inc(byte_cnt_q);
                if (href_fall) begin
                    line_cnt_d = line_inc(line_cnt_q);
                    byte_cnt_d = '0;
                end
                if (vs_rise || (line_cnt_q >= V_LINES_C)) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = mode_q ? ST_WAIT_VS : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d    = ST_IDLE;
            addr_clr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= 1'b0;
            addr_clr_q <= 1'b0;
            byte_cnt_q <= '0;
            line_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            addr_clr_q <= addr_clr_d;
            byte_cnt_q <= byte_cnt_d;
            line_cnt_q <= line_cnt_d;
        end
    end

    assign cap_en     = (state_q == ST_CAPTURE);
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DONE);
    assign addr_clr   = addr_clr_q;
    assign line_cnt   = line_cnt_q;

`ifdef CAP_FRAME_CHECK_EN
    localparam logic [BYTE_CNT_W-1:0] H_BYTES_C = BYTE_CNT_W'(H_BYTES);

    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (start_ok) err_d = 1'b0;
        if (state_q == ST_CAPTURE) begin
            if (href_fall && (byte_cnt_q != H_BYTES_C)) err_d = 1'b1;
            // a frame cut short by VSYNC is the only way to end with a wrong line count
            if (vs_rise && (line_cnt_q != V_LINES_C)) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;
`else
    localparam int unsigned h_bytes_unused = H_BYTES;

    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed/randomized bench for cam_capture_ctrl driven by a scaled camera model.
module tb_cam_capture_ctrl;

    localparam int H         = 16;
    localparam int V         = 6;
    localparam int BPL       = H + 4;
    localparam int NLINES    = V + 4;
    localparam int LINE_CLK  = BPL * 4;
    localparam int FRAME_CLK = NLINES * LINE_CLK;
`ifdef CAP_FRAME_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic       CAM_PCLK, CAM_HREF, CAM_VSYNC;
    logic       start, mode_cont, abort;
    logic       cap_en, addr_clr, busy, frame_done, err;
    logic [6:0] line_cnt;

    cam_capture_ctrl #(.H_BYTES(H), .V_LINES(V)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .CAM_PCLK  (CAM_PCLK),
        .CAM_HREF  (CAM_HREF),
        .CAM_VSYNC (CAM_VSYNC),
        .start     (start),
        .mode_cont (mode_cont),
        .abort     (abort),
        .cap_en    (cap_en),
        .addr_clr  (addr_clr),
        .busy      (busy),
        .frame_done(frame_done),
        .line_cnt  (line_cnt),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // camera position and per-frame geometry knobs
    int cyc = 0;
    int cut_line = -1;
    int cut_bytes = H;
    int act_lines = V;
    int vs_run = 0;

    // event tallies observed since the last clear_mon()
    int n_done, n_clr, n_cap, n_href_cap, n_blank, rise_cyc;
    bit cap_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        n_done = 0; n_clr = 0; n_cap = 0; n_href_cap = 0; n_blank = 0;
        rise_cyc = -1;
    endtask

    task automatic tick();
        int line, slot, nb;
        logic vs, hr, pc;
        @(negedge clk);
        if (frame_done === 1'b1) n_done++;
        if (addr_clr === 1'b1) n_clr++;
        if (cap_en === 1'b1) n_cap++;
        if (cap_en === 1'b1 && !cap_prev && rise_cyc < 0) rise_cyc = cyc;
        if (cap_en === 1'b1 && vs_run >= 4) n_blank++;
        cap_prev = (cap_en === 1'b1);
        line = cyc / LINE_CLK;
        slot = (cyc % LINE_CLK) / 4;
        nb   = (line == cut_line) ? cut_bytes : H;
        vs   = (line < 2);
        hr   = (line >= 3) && (line < 3 + act_lines) && (slot < nb);
        pc   = ((cyc % 4) >= 2);
        if (CAM_HREF && !hr && cap_en === 1'b1) n_href_cap++;
        CAM_VSYNC = vs;
        CAM_HREF  = hr;
        CAM_PCLK  = pc;
        vs_run = vs ? vs_run + 1 : 0;
        cyc = (cyc + 1) % FRAME_CLK;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_to_frame_end();
        do tick(); while (cyc != 0);
    endtask

    task automatic start_mid_frame(input logic mode);
        run_to_frame_end();
        run_cycles(10 + $urandom_range(0, FRAME_CLK - 30));
        start = 1'b1;
        mode_cont = mode;
        tick();
        start = 1'b0;
        mode_cont = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cap_en"}, 32'(cap_en), 0);
        check({tag, "_addr_clr"}, 32'(addr_clr), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_frame_done"}, 32'(frame_done), 0);
        check({tag, "_line_cnt"}, 32'(line_cnt), 0);
        check({tag, "_err"}, 32'(err), 0);
    endtask

    initial begin
        int l_abort;
        rst_n = 1'b0; start = 1'b0; mode_cont = 1'b0; abort = 1'b0;
        CAM_PCLK = 1'b0; CAM_HREF = 1'b0; CAM_VSYNC = 1'b0;
        cap_prev = 1'b0;
        clear_mon();

        // reset state
        run_cycles(4);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // start and abort together: abort wins
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        tick();
        check("start_abort_busy", 32'(busy), 0);

        // single snapshot requested mid-frame
        start_mid_frame(1'b0);
        check("snap_busy", 32'(busy), 1);
        clear_mon();
        run_to_frame_end();
        check("snap_no_cap_midframe", n_cap, 0);
        run_cycles(4 * LINE_CLK);
        check("snap_first_line_cnt", 32'(line_cnt), 1);
        check("snap_cap_en_mid", 32'(cap_en), 1);
        start = 1'b1; mode_cont = 1'b1;
        tick();
        start = 1'b0; mode_cont = 1'b0;
        run_to_frame_end();
        check("snap_frame_done", n_done, 1);
        check("snap_addr_clr", n_clr, 1);
        check("snap_href_lines", n_href_cap, V);
        check("snap_line_cnt", 32'(line_cnt), V);
        check("snap_busy_end", 32'(busy), 0);
        check("snap_err", 32'(err), 0);
        check("snap_cap_in_blank", n_blank, 0);
        check("snap_cap_latency", rise_cyc, 2 * LINE_CLK + 3);
        run_cycles(3 * LINE_CLK);
        check("snap_busy_start_ignored", 32'(busy), 0);
        check("snap_single_done", n_done, 1);

        // continuous mode over three frames
        start_mid_frame(1'b1);
        run_to_frame_end();
        clear_mon();
        run_cycles(3 * FRAME_CLK);
        check("cont_frame_done", n_done, 3);
        check("cont_addr_clr", n_clr, 3);
        check("cont_href_lines", n_href_cap, 3 * V);
        check("cont_cap_in_blank", n_blank, 0);
        check("cont_busy", 32'(busy), 1);

        // abort partway through the fourth frame
        l_abort = $urandom_range(1, V - 1);
        clear_mon();
        run_cycles((3 + l_abort) * LINE_CLK);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_cap_en", 32'(cap_en), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_line_cnt", 32'(line_cnt), l_abort);
        run_to_frame_end();
        run_cycles(4 * LINE_CLK);
        check("abort_no_done", n_done, 0);
        check("abort_line_hold", 32'(line_cnt), l_abort);

        // one short line inside the captured frame
        start_mid_frame(1'b0);
        run_to_frame_end();
        cut_line = 3 + $urandom_range(0, V - 1);
        cut_bytes = H - 2;
        clear_mon();
        run_to_frame_end();
        cut_line = -1;
        check("cut_frame_done", n_done, 1);
        check("cut_line_cnt", 32'(line_cnt), V);
        check("cut_err", 32'(err), CHK);
        run_cycles(FRAME_CLK);
        check("cut_err_held", 32'(err), CHK);

        // accepted start clears err; then a frame ended early by VSYNC
        start_mid_frame(1'b0);
        check("err_clr_on_start", 32'(err), 0);
        run_to_frame_end();
        act_lines = V - 2;
        clear_mon();
        run_to_frame_end();
        act_lines = V;
        run_cycles(20);
        check("short_frame_done", n_done, 1);
        check("short_line_cnt", 32'(line_cnt), V - 2);
        check("short_err", 32'(err), CHK);
        check("short_busy", 32'(busy), 0);

        // reset pulse mid-capture, then a clean capture
        start_mid_frame(1'b0);
        run_to_frame_end();
        clear_mon();
        run_cycles(5 * LINE_CLK);
        check("rst_mid_cap_en_before", 32'(cap_en), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_all_zero("rst_mid");
        run_to_frame_end();
        check("rst_mid_no_done", n_done, 0);
        start_mid_frame(1'b0);
        run_to_frame_end();
        clear_mon();
        run_to_frame_end();
        check("post_rst_done", n_done, 1);
        check("post_rst_line_cnt", 32'(line_cnt), V);
        check("post_rst_href_lines", n_href_cap, V);
        check("post_rst_busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
